bsg_nasti_client_resp_buf: RTL and testbench
============================================

# bsg_nasti_client_resp_buf

Parametrised, buffered NASTI read-response generator for the client side of the tunnel. It accepts read-data beats from the tunnel demux, counts beats against the burst length captured from the AR side, and generates `last` itself. It flags protocol mismatches with SLVERR and decouples tunnel timing from the NASTI R channel through an output FIFO. It sits between the tunnel demux response port and the NASTI R channel of the client bridge, replacing the unbuffered pass-through converter.

## Interface
Parameters:
- `data_width_p`, 64, R-channel data width.
- `id_width_p`, 5, transaction ID width.
- `els_p`, 4, output FIFO depth; legal values ≥2, power of two.
- `len_els_p`, 4, burst-length queue depth; legal values ≥1.

Ports:
- `clk_i` in 1: single clock. All state is on its rising edge.
- `reset_n_i` in 1: reset, asynchronous and active-low.
- `len_v_i` in 1: valid for a burst-length entry, pushed by the AR path. One entry per accepted AR.
- `len_i` in 8: NASTI arlen. Beats per burst = `len_i`+1.
- `len_ready_o` out 1: the length queue is not full.
- `resp_v_i` in 1: a tunnel response beat is valid.
- `resp_id_i` in `id_width_p`: beat ID.
- `resp_data_i` in `data_width_p`: beat data.
- `resp_last_i` in 1: the sender's last flag.
- `resp_yumi_o` out 1: the beat is consumed this cycle.
- `r_valid_o`, `r_ready_i`: NASTI R handshake.
- `r_id_o` out `id_width_p`: R-channel ID.
- `r_data_o` out `data_width_p`: R-channel data.
- `r_resp_o` out 2: R-channel response code.
- `r_last_o` out 1: R-channel last flag.
- `err_count_o` out 8: saturating count of last-flag mismatches.
- `err_clr_i` in 1: synchronous clear of `err_count_o`.

## Operation
- **Length queue:** FIFO of `len_els_p` entries.
  - Push on `len_v_i & len_ready_o`.
  - The head is the current burst length `L`; the head is valid when the queue is non-empty.
- **Beat counter** `cnt`, 8 bits:
  - On each accepted beat, `end_beat` = (`cnt`==`L`).
  - If `end_beat`: `cnt`←0 and the length queue pops. Otherwise `cnt`←`cnt`+1.
- **Accept rule:** `resp_yumi_o` = `resp_v_i` & length head valid & (output FIFO count<`els_p` | (`r_valid_o` & `r_ready_i`)).
  - Beats arriving with no length entry stall; they are never dropped.
- **Output FIFO entry written per accepted beat:**
  - `r_id_o` = `resp_id_i`.
  - `r_data_o` = `resp_data_i`.
  - `r_last_o` = `end_beat`. This is generated internally and is never taken from `resp_last_i`.
  - `r_resp_o` = 2'b10 (SLVERR) if `resp_last_i` ≠ `end_beat`, else 2'b00 (OKAY).
- **Mismatch handling:**
  - On a mismatch, `err_count_o` increments and saturates at 255.
  - If `err_clr_i` and a mismatch occur in the same cycle, the clear wins and the result is 0.
  - Burst framing always follows `L`. An early `resp_last_i` does not terminate the burst; a missing one does not extend it.
- **Output side:** `r_valid_o` = output FIFO non-empty. Pop on `r_valid_o` & `r_ready_i`.
- **Field stability:** while `r_valid_o` is high and `r_ready_i` is low, all R fields hold stable.
- **Boundaries:**
  - Length `len_i`=0 means single-beat bursts: `r_last_o`=1 on every beat, and the queue pops every beat.
  - `len_i`=255 means 256 beats. `cnt` reaches 255 without overflow, then returns to 0.
  - A length push into an empty queue in the same cycle as a beat arrives: the beat waits one cycle (no bypass).
  - A length pop and push in the same cycle with the queue full: the push is refused (`len_ready_o`=0 when full).

## Timing
- **Reset (asynchronous, effective immediately):**
  - `r_valid_o`=0, `resp_yumi_o`=0, `len_ready_o`=1.
  - `cnt`=0, `err_count_o`=0, both FIFOs empty.
  - `r_id_o`, `r_data_o`, `r_resp_o`, `r_last_o` read 0.
- **Reset mid-burst:** all in-flight beats and length entries are discarded. After release the block accepts a fresh length entry and the counter restarts from 0.
- **Latency:**
  - Accepted beat → `r_valid_o`: 1 cycle. Registered FIFO, no combinational path from `resp_*` to `r_*`.
  - Length push → beats eligible: next cycle.
- **Throughput:** 1 beat/cycle sustained while `r_ready_i`=1 and length entries are available.
- **Combinational dependencies:**
  - `resp_yumi_o` depends combinationally on `r_ready_i` (full-FIFO pass-through case) and on `resp_v_i`.
  - `r_valid_o` depends only on state.

## Test plan
- **Reset and single-beat:** reset, push `len_i`=0, send one beat (id 3, data 0xA5, last=1) -> `r_valid_o` one cycle after yumi with id 3, data 0xA5, `r_last_o`=1, `r_resp_o`=00, `err_count_o`=0.
- **Full-rate burst:** push `len_i`=3, send 4 beats back to back with `r_ready_i`=1, last on beat 4 -> 4 consecutive R beats, `r_last_o` only on the 4th, all OKAY, yumi high 4 consecutive cycles.
- **Backpressure:** `r_ready_i`=0, `len_i`=7, stream 8 beats -> exactly `els_p`=4 accepted, then `resp_yumi_o`=0 and R fields held stable. Release `r_ready_i` -> remaining 4 beats flow, order preserved, last on the 8th.
- **Mismatch:** `len_i`=1, sender asserts last on beat 1 and not on beat 2 -> both beats SLVERR, `r_last_o` on beat 2 only, `err_count_o`=2. Assert `err_clr_i` -> 0.
- **Length starvation and queue full:**
  - Beats with the length queue empty -> no yumi. Push length -> acceptance starts the following cycle.
  - Push 5 lengths with `len_els_p`=4 -> `len_ready_o`=0 on the 5th.
- **Async reset mid-burst:** drop `reset_n_i` mid-clock during beat 2 of 4 -> `r_valid_o`=0 immediately. After release, a new `len_i`=0 burst completes normally with `r_last_o`=1.

Source files
------------

// File: rtl/bsg_nasti_client_resp_buf.sv
// Buffered NASTI R-channel generator: frames tunnel read beats into bursts using
// AR-side lengths, generates r_last internally and flags last-flag mismatches.
module bsg_nasti_client_resp_buf #(
    parameter int data_width_p = 64,
    parameter int id_width_p   = 5,
    parameter int els_p        = 4,
    parameter int len_els_p    = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,

    input  logic                    len_v_i,
    input  logic [7:0]              len_i,
    output logic                    len_ready_o,

    input  logic                    resp_v_i,
    input  logic [id_width_p-1:0]   resp_id_i,
    input  logic [data_width_p-1:0] resp_data_i,
    input  logic                    resp_last_i,
    output logic                    resp_yumi_o,

    output logic                    r_valid_o,
    input  logic                    r_ready_i,
    output logic [id_width_p-1:0]   r_id_o,
    output logic [data_width_p-1:0] r_data_o,
    output logic [1:0]              r_resp_o,
    output logic                    r_last_o,

    output logic [7:0]              err_count_o,
    input  logic                    err_clr_i
);

    localparam int lptr_w = (len_els_p > 1) ? $clog2(len_els_p) : 1;
    localparam int lcnt_w = $clog2(len_els_p + 1);
    localparam int optr_w = $clog2(els_p);
    localparam int ocnt_w = $clog2(els_p) + 1;
    localparam int ent_w  = id_width_p + data_width_p + 3;

    // ---------------- burst-length queue ----------------
    logic [7:0]        len_mem [len_els_p];
    logic [lptr_w-1:0] len_wr_ptr_reg, len_rd_ptr_reg;
    logic [lcnt_w-1:0] len_count_reg;
    logic              len_full, len_head_v, len_push, len_pop;
    logic [7:0]        len_head;

    assign len_full    = (len_count_reg == lcnt_w'(len_els_p));
    assign len_head_v  = (len_count_reg != '0);
    assign len_ready_o = ~len_full;
    assign len_push    = len_v_i & ~len_full;
    assign len_head    = len_mem[len_rd_ptr_reg];

    always_ff @(posedge clk_i) begin
        if (len_push) begin
            len_mem[len_wr_ptr_reg] <= len_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            len_wr_ptr_reg <= '0;
            len_rd_ptr_reg <= '0;
            len_count_reg  <= '0;
        end else begin
            if (len_push) begin
                len_wr_ptr_reg <= (len_wr_ptr_reg == lptr_w'(len_els_p - 1)) ? '0 : len_wr_ptr_reg + 1'b1;
            end
            if (len_pop) begin
                len_rd_ptr_reg <= (len_rd_ptr_reg == lptr_w'(len_els_p - 1)) ? '0 : len_rd_ptr_reg + 1'b1;
            end
            case ({len_push, len_pop})
                2'b10:   len_count_reg <= len_count_reg + 1'b1;
                2'b01:   len_count_reg <= len_count_reg - 1'b1;
                default: len_count_reg <= len_count_reg;
            endcase
        end
    end

    // ---------------- output FIFO ----------------
    logic [ent_w-1:0]  out_mem [els_p];
    logic [optr_w-1:0] out_wr_ptr_reg, out_rd_ptr_reg;
    logic [ocnt_w-1:0] out_count_reg;
    logic              out_full, out_pop, beat_acc;
    logic [ent_w-1:0]  wr_word, rd_word;

    assign out_full  = (out_count_reg == ocnt_w'(els_p));
    assign r_valid_o = (out_count_reg != '0);
    assign out_pop   = r_valid_o & r_ready_i;

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign beat_acc    = resp_v_i & len_head_v & (~out_full | out_pop);
    assign resp_yumi_o = beat_acc;

    // ---------------- beat framing ----------------
    logic [7:0] cnt_reg;
    logic       end_beat, mismatch;

    assign end_beat = (cnt_reg == len_head);
    assign len_pop  = beat_acc & end_beat;
    assign mismatch = beat_acc & (resp_last_i != end_beat);

    assign wr_word = {resp_id_i, resp_data_i, (mismatch ? 2'b10 : 2'b00), end_beat};

    always_ff @(posedge clk_i) begin
        if (beat_acc) begin
            out_mem[out_wr_ptr_reg] <= wr_word;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            out_wr_ptr_reg <= '0;
            out_rd_ptr_reg <= '0;
            out_count_reg  <= '0;
        end else begin
            if (beat_acc) begin
                out_wr_ptr_reg <= out_wr_ptr_reg + 1'b1;
            end
            if (out_pop) begin
                out_rd_ptr_reg <= out_rd_ptr_reg + 1'b1;
            end
            case ({beat_acc, out_pop})
                2'b10:   out_count_reg <= out_count_reg + 1'b1;
                2'b01:   out_count_reg <= out_count_reg - 1'b1;
                default: out_count_reg <= out_count_reg;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_reg <= '0;
        end else if (beat_acc) begin
            cnt_reg <= end_beat ? 8'd0 : cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_count_o <= '0;
        end else if (err_clr_i) begin
            err_count_o <= '0;
        end else if (mismatch && (err_count_o != 8'hFF)) begin
            err_count_o <= err_count_o + 8'd1;
        end
    end

    // Fields read zero when empty so stale storage never shows on the bus.
    assign rd_word = r_valid_o ? out_mem[out_rd_ptr_reg] : '0;
    assign r_id_o   = rd_word[ent_w-1 -: id_width_p];
    assign r_data_o = rd_word[data_width_p+2 -: data_width_p];
    assign r_resp_o = rd_word[2:1];
    assign r_last_o = rd_word[0];

endmodule

// File: tb/tb_bsg_nasti_client_resp_buf.sv
// Directed bench for bsg_nasti_client_resp_buf: inputs change on the falling edge,
// outputs are checked between edges against hand-computed values.
module tb_bsg_nasti_client_resp_buf;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        len_v;
    logic [7:0]  len;
    logic        len_ready;
    logic        resp_v;
    logic [4:0]  resp_id;
    logic [63:0] resp_data;
    logic        resp_last;
    logic        resp_yumi;
    logic        r_valid;
    logic        r_ready;
    logic [4:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [7:0]  err_count;
    logic        err_clr;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    bsg_nasti_client_resp_buf dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .len_v_i     (len_v),
        .len_i       (len),
        .len_ready_o (len_ready),
        .resp_v_i    (resp_v),
        .resp_id_i   (resp_id),
        .resp_data_i (resp_data),
        .resp_last_i (resp_last),
        .resp_yumi_o (resp_yumi),
        .r_valid_o   (r_valid),
        .r_ready_i   (r_ready),
        .r_id_o      (r_id),
        .r_data_o    (r_data),
        .r_resp_o    (r_resp),
        .r_last_o    (r_last),
        .err_count_o (err_count),
        .err_clr_i   (err_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic beat(input logic [4:0] id, input logic [63:0] data, input logic last);
        resp_v    = 1'b1;
        resp_id   = id;
        resp_data = data;
        resp_last = last;
    endtask

    initial begin
        int j;
        reset_n = 1'b0; len_v = 1'b0; len = '0; resp_v = 1'b0; resp_id = '0;
        resp_data = '0; resp_last = 1'b0; r_ready = 1'b0; err_clr = 1'b0;

        // reset state
        tick;
        chk("rst_r_valid", 64'(r_valid), 64'd0);
        chk("rst_yumi", 64'(resp_yumi), 64'd0);
        chk("rst_len_ready", 64'(len_ready), 64'd1);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_r_data", r_data, 64'd0);
        chk("rst_r_id", 64'(r_id), 64'd0);
        reset_n = 1'b1;
        tick;

        // starvation, then single-beat burst (no same-cycle bypass)
        beat(5'd3, 64'hA5, 1'b1);
        #1 chk("starve_yumi0", 64'(resp_yumi), 64'd0);
        tick;
        chk("starve_yumi1", 64'(resp_yumi), 64'd0);
        len_v = 1'b1; len = 8'd0;
        #1 chk("push_cycle_yumi", 64'(resp_yumi), 64'd0);
        tick;
        len_v = 1'b0;
        #1 chk("single_yumi", 64'(resp_yumi), 64'd1);
        chk("single_rvalid_pre", 64'(r_valid), 64'd0);
        tick;
        resp_v = 1'b0;
        chk("single_r_valid", 64'(r_valid), 64'd1);
        chk("single_r_id", 64'(r_id), 64'd3);
        chk("single_r_data", r_data, 64'hA5);
        chk("single_r_last", 64'(r_last), 64'd1);
        chk("single_r_resp", 64'(r_resp), 64'd0);
        chk("single_err", 64'(err_count), 64'd0);
        r_ready = 1'b1;
        tick;
        chk("single_drained", 64'(r_valid), 64'd0);

        // full-rate 4-beat burst
        len_v = 1'b1; len = 8'd3;
        tick;
        len_v = 1'b0;
        for (int k = 0; k < 4; k++) begin
            beat(5'd4, 64'h10 + 64'(k), k == 3);
            #1 chk("burst_yumi", 64'(resp_yumi), 64'd1);
            tick;
            chk("burst_r_valid", 64'(r_valid), 64'd1);
            chk("burst_r_data", r_data, 64'h10 + 64'(k));
            chk("burst_r_last", 64'(r_last), 64'(k == 3));
            chk("burst_r_resp", 64'(r_resp), 64'd0);
        end
        resp_v = 1'b0;
        tick;
        chk("burst_drained", 64'(r_valid), 64'd0);

        // backpressure: 8-beat burst into a 4-deep FIFO
        r_ready = 1'b0;
        len_v = 1'b1; len = 8'd7;
        tick;
        len_v = 1'b0;
        j = 0;
        for (int k = 0; k < 4; k++) begin
            beat(5'd5, 64'h100 + 64'(j), 1'b0);
            #1 chk("bp_fill_yumi", 64'(resp_yumi), 64'd1);
            tick;
            j++;
        end
        beat(5'd5, 64'h104, 1'b0);
        #1 chk("bp_full_yumi", 64'(resp_yumi), 64'd0);
        chk("bp_hold_data", r_data, 64'h100);
        tick;
        chk("bp_full_yumi2", 64'(resp_yumi), 64'd0);
        chk("bp_hold_data2", r_data, 64'h100);
        chk("bp_hold_id", 64'(r_id), 64'd5);
        chk("bp_hold_last", 64'(r_last), 64'd0);
        r_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (j < 8) beat(5'd5, 64'h100 + 64'(j), j == 7);
            else resp_v = 1'b0;
            #1 chk("bp_r_valid", 64'(r_valid), 64'd1);
            chk("bp_r_data", r_data, 64'h100 + 64'(k));
            chk("bp_r_last", 64'(r_last), 64'(k == 7));
            if (j < 8) chk("bp_drain_yumi", 64'(resp_yumi), 64'd1);
            tick;
            if (j < 8) j++;
        end
        resp_v = 1'b0;
        #1 chk("bp_drained", 64'(r_valid), 64'd0);

        // last-flag mismatch on a 2-beat burst
        r_ready = 1'b0;
        len_v = 1'b1; len = 8'd1;
        tick;
        len_v = 1'b0;
        beat(5'd2, 64'h20, 1'b1);
        tick;
        chk("mm_err1", 64'(err_count), 64'd1);
        beat(5'd2, 64'h21, 1'b0);
        tick;
        resp_v = 1'b0;
        chk("mm_err2", 64'(err_count), 64'd2);
        chk("mm_b0_resp", 64'(r_resp), 64'd2);
        chk("mm_b0_last", 64'(r_last), 64'd0);
        chk("mm_b0_data", r_data, 64'h20);
        r_ready = 1'b1;
        tick;
        chk("mm_b1_resp", 64'(r_resp), 64'd2);
        chk("mm_b1_last", 64'(r_last), 64'd1);
        chk("mm_b1_data", r_data, 64'h21);
        tick;
        chk("mm_drained", 64'(r_valid), 64'd0);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("mm_clr", 64'(err_count), 64'd0);

        // length queue full; pop+push while full refuses the push
        for (int k = 0; k < 4; k++) begin
            len_v = 1'b1; len = 8'd0;
            #1 chk("lq_ready", 64'(len_ready), 64'd1);
            tick;
        end
        #1 chk("lq_full_ready", 64'(len_ready), 64'd0);
        beat(5'd1, 64'h30, 1'b1);
        #1 chk("lq_poppush_yumi", 64'(resp_yumi), 64'd1);
        chk("lq_poppush_ready", 64'(len_ready), 64'd0);
        tick;
        len_v = 1'b0;
        for (int k = 1; k < 4; k++) begin
            beat(5'd1, 64'h30 + 64'(k), 1'b1);
            #1 chk("lq_drain_yumi", 64'(resp_yumi), 64'd1);
            chk("lq_drain_last", 64'(r_last), 64'd1);
            tick;
        end
        #1 chk("lq_empty_yumi", 64'(resp_yumi), 64'd0);
        resp_v = 1'b0;
        tick;
        tick;

        // 256-beat burst: counter reaches 255 and wraps
        len_v = 1'b1; len = 8'd255;
        tick;
        len_v = 1'b0;
        for (int k = 0; k < 256; k++) begin
            beat(5'd9, 64'(k), k == 255);
            tick;
            chk("b256_r_last", 64'(r_last), 64'(k == 255));
        end
        resp_v = 1'b0;
        chk("b256_err", 64'(err_count), 64'd0);
        tick;

        // async reset mid-burst
        r_ready = 1'b0;
        len_v = 1'b1; len = 8'd3;
        tick;
        len_v = 1'b0;
        beat(5'd6, 64'h40, 1'b0);
        tick;
        beat(5'd6, 64'h41, 1'b0);
        #1 chk("ar_pre_valid", 64'(r_valid), 64'd1);
        #1 reset_n = 1'b0;
        #1 chk("ar_r_valid", 64'(r_valid), 64'd0);
        chk("ar_yumi", 64'(resp_yumi), 64'd0);
        chk("ar_len_ready", 64'(len_ready), 64'd1);
        chk("ar_r_data", r_data, 64'd0);
        resp_v = 1'b0;
        tick;
        reset_n = 1'b1;
        tick;
        len_v = 1'b1; len = 8'd0;
        tick;
        len_v = 1'b0;
        beat(5'd7, 64'h77, 1'b1);
        #1 chk("ar_new_yumi", 64'(resp_yumi), 64'd1);
        tick;
        resp_v = 1'b0;
        chk("ar_new_valid", 64'(r_valid), 64'd1);
        chk("ar_new_last", 64'(r_last), 64'd1);
        chk("ar_new_resp", 64'(r_resp), 64'd0);
        chk("ar_new_data", r_data, 64'h77);
        chk("ar_new_id", 64'(r_id), 64'd7);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
